// File: rtl/pic_pkg.sv
// Shared encodings for the PIC control sequencer: FSM states, OCW2 command
// codes and OCW3 field positions.
package pic_pkg;

   typedef enum logic [1:0] {
      CMD_READY,
      WAIT_ICW2,
      WAIT_ICW3,
      WAIT_ICW4
   } cmd_state_t;

   typedef enum logic [1:0] {
      ACK_IDLE,
      ACK_1,
      ACK_2,
      ACK_POLL
   } ack_state_t;

   // OCW2 data[7:5]
   localparam logic [2:0] EOI_NONSPEC  = 3'b001;
   localparam logic [2:0] EOI_ROTATE   = 3'b101;
   localparam logic [2:0] AEOI_ROT_SET = 3'b100;
   localparam logic [2:0] AEOI_ROT_CLR = 3'b000;

   // OCW3 data[1:0] read select and poll bit
   localparam logic [1:0] RSEL_IRR = 2'b10;
   localparam logic [1:0] RSEL_ISR = 2'b11;
   localparam int unsigned OCW3_POLL_BIT = 2;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating-priority find-first over pending requests, plus the fully-nested
// check against the highest in-service level.
module pic_priority_resolver #(
   parameter int unsigned NUM_IRQ = 8,
   localparam int unsigned ID_WIDTH = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0]  pending,
   input  logic [NUM_IRQ-1:0]  in_service,
   input  logic [ID_WIDTH-1:0] lowest,
   output logic                winner_valid_c,
   output logic [ID_WIDTH-1:0] winner_id_c,
   output logic                isr_any_c,
   output logic [ID_WIDTH-1:0] isr_top_id_c
);

   logic [ID_WIDTH-1:0] start;
   logic [NUM_IRQ-1:0]  pend_rot;
   logic [NUM_IRQ-1:0]  isr_rot;
   logic [ID_WIDTH-1:0] pend_rank;
   logic [ID_WIDTH-1:0] isr_rank;
   logic                pend_any;
   logic                isr_any;

   // Rank 0 is the level just above the lowest-priority pointer.
   always_comb begin
      start     = lowest + ID_WIDTH'(1);
      pend_rot  = '0;
      isr_rot   = '0;
      pend_rank = '0;
      isr_rank  = '0;
      pend_any  = 1'b0;
      isr_any   = 1'b0;
      for (int k = 0; k < int'(NUM_IRQ); k++) begin
         pend_rot[k] = pending[start + ID_WIDTH'(k)];
         isr_rot[k]  = in_service[start + ID_WIDTH'(k)];
      end
      for (int k = int'(NUM_IRQ) - 1; k >= 0; k--) begin
         if (pend_rot[k]) begin
            pend_any  = 1'b1;
            pend_rank = ID_WIDTH'(k);
         end
         if (isr_rot[k]) begin
            isr_any  = 1'b1;
            isr_rank = ID_WIDTH'(k);
         end
      end
      winner_id_c    = pend_rank + start;
      isr_top_id_c   = isr_rank + start;
      isr_any_c      = isr_any;
      winner_valid_c = pend_any && (!isr_any || (pend_rank < isr_rank));
   end

endmodule

// File: rtl/pic_control_sequencer.sv
// Clocked 8259A-style control logic: ICW/OCW sequencing, IRR/ISR/IMR,
// rotating priority, 8086 two-pulse acknowledge, poll and register reads.
module pic_control_sequencer
   import pic_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               write_initial_command_word_1,
   input  logic               write_initial_command_word_2_4,
   input  logic               write_operation_control_word_1,
   input  logic               write_operation_control_word_2,
   input  logic               write_operation_control_word_3,
   input  logic               read,
   input  logic [7:0]         internal_data_bus,
   input  logic               interrupt_acknowledge_n,
   input  logic [NUM_IRQ-1:0] interrupt_request,
   output logic               interrupt_to_cpu,
   output logic               out_control_logic_data,
   output logic [7:0]         control_logic_data,
   output logic [NUM_IRQ-1:0] interrupt_mask,
   output logic [NUM_IRQ-1:0] in_service
);

   localparam int unsigned ID_WIDTH  = $clog2(NUM_IRQ);
   localparam int unsigned BASE_W    = 8 - ID_WIDTH;
   localparam int unsigned NUM_BYTES = NUM_IRQ / 8;
   localparam int unsigned PTR_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_IRQ - 1);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) + 32'd1 >= NUM_BYTES) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_WIDTH-1:0] id);
      return NUM_IRQ'(1) << id;
   endfunction

   cmd_state_t          cmd_state, cmd_n;
   ack_state_t          ack_state, ack_n;
   logic                ltim, ltim_n, sngl, sngl_n, ic4, ic4_n;
   logic                aeoi, aeoi_n, auto_rot, auto_rot_n;
   logic [BASE_W-1:0]   base, base_n;
   logic [ID_WIDTH-1:0] lowest, lowest_n;
   logic [NUM_IRQ-1:0]  irr, irr_n, isr, isr_n, imr, imr_n, req_d;
   logic [PTR_W-1:0]    mask_ptr, mask_ptr_n, rd_ptr, rd_ptr_n;
   logic                read_isr, read_isr_n;
   logic [ID_WIDTH-1:0] ack_id, ack_id_n;
   logic                ack_valid, ack_valid_n;
   logic                inta_d, read_d;
   logic                int_n, drv_n;
   logic [7:0]          dout_n;

   logic                winner_valid, isr_any;
   logic [ID_WIDTH-1:0] winner_id, isr_top_id, ack_sel;
   logic [NUM_IRQ-1:0]  isr_set, isr_clr, irr_clr, sel_vec;
   logic [7:0]          reg_byte;
   logic                wr_ready, inta_fall, inta_rise, read_rise, read_fall;

   pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_resolver (
      .pending        (irr & ~imr),
      .in_service     (isr),
      .lowest         (lowest),
      .winner_valid_c (winner_valid),
      .winner_id_c    (winner_id),
      .isr_any_c      (isr_any),
      .isr_top_id_c   (isr_top_id)
   );

   assign interrupt_mask = imr;
   assign in_service     = isr;

   always_comb begin
      cmd_n       = cmd_state;
      ack_n       = ack_state;
      ltim_n      = ltim;
      sngl_n      = sngl;
      ic4_n       = ic4;
      aeoi_n      = aeoi;
      auto_rot_n  = auto_rot;
      base_n      = base;
      lowest_n    = lowest;
      imr_n       = imr;
      mask_ptr_n  = mask_ptr;
      rd_ptr_n    = rd_ptr;
      read_isr_n  = read_isr;
      ack_id_n    = ack_id;
      ack_valid_n = ack_valid;
      int_n       = winner_valid && (ack_state == ACK_IDLE);
      drv_n       = 1'b0;
      dout_n      = '0;
      isr_set     = '0;
      isr_clr     = '0;
      irr_clr     = '0;
      wr_ready    = (cmd_state == CMD_READY);
      inta_fall   = inta_d & ~interrupt_acknowledge_n;
      inta_rise   = ~inta_d & interrupt_acknowledge_n;
      read_rise   = read & ~read_d;
      read_fall   = ~read & read_d;
      ack_sel     = winner_valid ? winner_id : LAST_ID;
      sel_vec     = read_isr ? isr : irr;
      reg_byte    = sel_vec[8*int'(rd_ptr) +: 8];

      // Initialisation sequence after ICW1
      if (write_initial_command_word_2_4) begin
         unique case (cmd_state)
            WAIT_ICW2: begin
               base_n = internal_data_bus[7:ID_WIDTH];
               cmd_n  = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : CMD_READY);
            end
            WAIT_ICW3: cmd_n = ic4 ? WAIT_ICW4 : CMD_READY;
            WAIT_ICW4: begin
               aeoi_n = internal_data_bus[1];
               cmd_n  = CMD_READY;
            end
            CMD_READY: ;
         endcase
      end

      // Acknowledge / poll / register-read sequencing
      unique case (ack_state)
         ACK_IDLE: begin
            if (read) begin
               drv_n  = 1'b1;
               dout_n = reg_byte;
            end
            if (read_fall) rd_ptr_n = ptr_inc(rd_ptr);
            if (inta_fall) begin
               ack_id_n    = ack_sel;
               ack_valid_n = winner_valid;
               if (winner_valid) begin
                  isr_set = onehot(winner_id);
                  irr_clr = onehot(winner_id);
               end
               ack_n = ACK_1;
            end else if (wr_ready && write_operation_control_word_3 &&
                         internal_data_bus[OCW3_POLL_BIT]) begin
               ack_id_n    = ack_sel;
               ack_valid_n = winner_valid;
               ack_n       = ACK_POLL;
            end
         end
         ACK_1: if (inta_rise) ack_n = ACK_2;
         ACK_2: begin
            if (!interrupt_acknowledge_n) begin
               drv_n  = 1'b1;
               dout_n = {base, ack_id};
            end
            if (inta_rise) begin
               ack_n = ACK_IDLE;
               if (aeoi && ack_valid) begin
                  isr_clr = onehot(ack_id);
                  if (auto_rot) lowest_n = ack_id;
               end
            end
         end
         ACK_POLL: begin
            if (read) begin
               drv_n  = 1'b1;
               dout_n = {ack_valid, 7'(ack_id)};
            end
            if (read_rise && ack_valid) begin
               isr_set = onehot(ack_id);
               irr_clr = onehot(ack_id);
            end
            if (read_fall) ack_n = ACK_IDLE;
         end
      endcase

      if (wr_ready && write_operation_control_word_1) begin
         imr_n[8*int'(mask_ptr) +: 8] = internal_data_bus;
         mask_ptr_n = ptr_inc(mask_ptr);
      end

      // EOI clears the highest in-service level as it was before this cycle's set
      if (wr_ready && write_operation_control_word_2) begin
         case (internal_data_bus[7:5])
            EOI_NONSPEC, EOI_ROTATE: begin
               if (isr_any) begin
                  isr_clr = isr_clr | onehot(isr_top_id);
                  if (internal_data_bus[7:5] == EOI_ROTATE) lowest_n = isr_top_id;
               end
            end
            AEOI_ROT_SET: auto_rot_n = 1'b1;
            AEOI_ROT_CLR: auto_rot_n = 1'b0;
            default: ;
         endcase
      end

      if (wr_ready && write_operation_control_word_3) begin
         mask_ptr_n = '0;
         rd_ptr_n   = '0;
         if (internal_data_bus[1:0] == RSEL_IRR) read_isr_n = 1'b0;
         else if (internal_data_bus[1:0] == RSEL_ISR) read_isr_n = 1'b1;
      end

      irr_n = (ltim ? interrupt_request : (irr | (interrupt_request & ~req_d))) & ~irr_clr;
      isr_n = (isr | isr_set) & ~isr_clr;

      // ICW1 restarts initialisation and overrides everything else this cycle
      if (write_initial_command_word_1) begin
         cmd_n       = WAIT_ICW2;
         ack_n       = ACK_IDLE;
         ltim_n      = internal_data_bus[3];
         sngl_n      = internal_data_bus[1];
         ic4_n       = internal_data_bus[0];
         aeoi_n      = 1'b0;
         auto_rot_n  = 1'b0;
         base_n      = '0;
         lowest_n    = LAST_ID;
         irr_n       = '0;
         isr_n       = '0;
         imr_n       = '0;
         mask_ptr_n  = '0;
         rd_ptr_n    = '0;
         read_isr_n  = 1'b0;
         ack_id_n    = '0;
         ack_valid_n = 1'b0;
         int_n       = 1'b0;
         drv_n       = 1'b0;
         dout_n      = '0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmd_state              <= CMD_READY;
         ack_state              <= ACK_IDLE;
         ltim                   <= 1'b0;
         sngl                   <= 1'b0;
         ic4                    <= 1'b0;
         aeoi                   <= 1'b0;
         auto_rot               <= 1'b0;
         base                   <= '0;
         lowest                 <= LAST_ID;
         irr                    <= '0;
         isr                    <= '0;
         imr                    <= '0;
         req_d                  <= '0;
         mask_ptr               <= '0;
         rd_ptr                 <= '0;
         read_isr               <= 1'b0;
         ack_id                 <= '0;
         ack_valid              <= 1'b0;
         inta_d                 <= 1'b1;
         read_d                 <= 1'b0;
         interrupt_to_cpu       <= 1'b0;
         out_control_logic_data <= 1'b0;
         control_logic_data     <= '0;
      end else begin
         cmd_state              <= cmd_n;
         ack_state              <= ack_n;
         ltim                   <= ltim_n;
         sngl                   <= sngl_n;
         ic4                    <= ic4_n;
         aeoi                   <= aeoi_n;
         auto_rot               <= auto_rot_n;
         base                   <= base_n;
         lowest                 <= lowest_n;
         irr                    <= irr_n;
         isr                    <= isr_n;
         imr                    <= imr_n;
         req_d                  <= interrupt_request;
         mask_ptr               <= mask_ptr_n;
         rd_ptr                 <= rd_ptr_n;
         read_isr               <= read_isr_n;
         ack_id                 <= ack_id_n;
         ack_valid              <= ack_valid_n;
         inta_d                 <= interrupt_acknowledge_n;
         read_d                 <= read;
         interrupt_to_cpu       <= int_n;
         out_control_logic_data <= drv_n;
         control_logic_data     <= dout_n;
      end
   end

endmodule

// File: tb/tb_pic_control_sequencer.sv
// Directed bench: an 8-line and a 16-line sequencer share the command bus,
// each scenario checks hand-computed outputs.
module tb_pic_control_sequencer;

   localparam logic [4:0] S_ICW1  = 5'b00001;
   localparam logic [4:0] S_ICW24 = 5'b00010;
   localparam logic [4:0] S_OCW1  = 5'b00100;
   localparam logic [4:0] S_OCW2  = 5'b01000;
   localparam logic [4:0] S_OCW3  = 5'b10000;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [4:0]  stb;
   logic        read;
   logic [7:0]  bus;
   logic        inta_n;
   logic [7:0]  ir8;
   logic [15:0] ir16;

   logic        int8, en8, int16, en16;
   logic [7:0]  data8, data16, imr8, isr8;
   logic [15:0] imr16, isr16;

   int checks = 0;
   int failures = 0;

   always #5 clock = ~clock;

   pic_control_sequencer #(.NUM_IRQ(8)) dut8 (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .write_initial_command_word_1   (stb[0]),
      .write_initial_command_word_2_4 (stb[1]),
      .write_operation_control_word_1 (stb[2]),
      .write_operation_control_word_2 (stb[3]),
      .write_operation_control_word_3 (stb[4]),
      .read                           (read),
      .internal_data_bus              (bus),
      .interrupt_acknowledge_n        (inta_n),
      .interrupt_request              (ir8),
      .interrupt_to_cpu               (int8),
      .out_control_logic_data         (en8),
      .control_logic_data             (data8),
      .interrupt_mask                 (imr8),
      .in_service                     (isr8)
   );

   pic_control_sequencer #(.NUM_IRQ(16)) dut16 (
      .clock                          (clock),
      .reset_n                        (reset_n),
      .write_initial_command_word_1   (stb[0]),
      .write_initial_command_word_2_4 (stb[1]),
      .write_operation_control_word_1 (stb[2]),
      .write_operation_control_word_2 (stb[3]),
      .write_operation_control_word_3 (stb[4]),
      .read                           (read),
      .internal_data_bus              (bus),
      .interrupt_acknowledge_n        (inta_n),
      .interrupt_request              (ir16),
      .interrupt_to_cpu               (int16),
      .out_control_logic_data         (en16),
      .control_logic_data             (data16),
      .interrupt_mask                 (imr16),
      .in_service                     (isr16)
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [4:0] s, input logic [7:0] d);
      stb = s;
      bus = d;
      tick();
      stb = '0;
      bus = '0;
   endtask

   task automatic init(input logic [7:0] i1, input logic [7:0] i2,
                       input logic [7:0] i4, input logic [7:0] mask);
      wr(S_ICW1, i1);
      wr(S_ICW24, i2);
      wr(S_ICW24, i4);
      wr(S_OCW1, mask);
   endtask

   // Two INTA# pulses; captures the bus drive during the second pulse
   task automatic do_inta(output logic [7:0] v8, output logic e8, output logic [7:0] v16);
      inta_n = 1'b0; tick(); tick();
      inta_n = 1'b1; tick(); tick();
      inta_n = 1'b0; tick();
      v8  = data8;
      e8  = en8;
      v16 = data16;
      inta_n = 1'b1; tick(); tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(); tick();
      checks++; if (int8 !== 1'b0) begin failures++; $display("FAIL reset_int: got %b expected 0", int8); end
      checks++; if (en8 !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", en8); end
      checks++; if (data8 !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", data8); end
      checks++; if (imr16 !== 16'h0000 || imr8 !== 8'h00) begin failures++; $display("FAIL reset_imr: got %h/%h expected 0/0", imr8, imr16); end
      checks++; if (isr16 !== 16'h0000 || isr8 !== 8'h00) begin failures++; $display("FAIL reset_isr: got %h/%h expected 0/0", isr8, isr16); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic_ack();
      init(8'h13, 8'h20, 8'h01, 8'h00);
      ir8 = 8'h08; tick();
      checks++; if (int8 !== 1'b0) begin failures++; $display("FAIL basic_int_early: got %b expected 0", int8); end
      tick();
      ir8 = 8'h00;
      checks++; if (int8 !== 1'b1) begin failures++; $display("FAIL basic_int: got %b expected 1", int8); end
      inta_n = 1'b0; tick();
      checks++; if (isr8 !== 8'h08) begin failures++; $display("FAIL basic_isr_ack1: got %h expected 08", isr8); end
      checks++; if (en8 !== 1'b0) begin failures++; $display("FAIL basic_en_ack1: got %b expected 0", en8); end
      tick();
      checks++; if (int8 !== 1'b0) begin failures++; $display("FAIL basic_int_held: got %b expected 0", int8); end
      inta_n = 1'b1; tick(); tick();
      inta_n = 1'b0; tick();
      checks++; if (en8 !== 1'b1 || data8 !== 8'h23) begin failures++; $display("FAIL basic_vector: got en=%b data=%h expected en=1 data=23", en8, data8); end
      inta_n = 1'b1; tick();
      checks++; if (en8 !== 1'b0) begin failures++; $display("FAIL basic_en_release: got %b expected 0", en8); end
      tick();
      checks++; if (isr8 !== 8'h08) begin failures++; $display("FAIL basic_isr_hold: got %h expected 08", isr8); end
      wr(S_OCW2, 8'h20);
      checks++; if (isr8 !== 8'h00) begin failures++; $display("FAIL basic_eoi: got %h expected 00", isr8); end
      wr(S_OCW2, 8'h20);
      checks++; if (isr8 !== 8'h00) begin failures++; $display("FAIL basic_eoi_empty: got %h expected 00", isr8); end
   endtask

   task automatic test_aeoi_rotate();
      logic [7:0] v8, v16;
      logic       e8;
      init(8'h13, 8'h20, 8'h03, 8'h00);
      wr(S_OCW2, 8'h80);
      ir8 = 8'h02; tick(); ir8 = 8'h00; tick();
      checks++; if (int8 !== 1'b1) begin failures++; $display("FAIL aeoi_int1: got %b expected 1", int8); end
      do_inta(v8, e8, v16);
      checks++; if (v8 !== 8'h21) begin failures++; $display("FAIL aeoi_vec_ir1: got %h expected 21", v8); end
      checks++; if (isr8 !== 8'h00) begin failures++; $display("FAIL aeoi_isr_ir1: got %h expected 00", isr8); end
      ir8 = 8'h05; tick(); ir8 = 8'h00; tick();
      do_inta(v8, e8, v16);
      checks++; if (v8 !== 8'h22) begin failures++; $display("FAIL aeoi_rotate_first: got %h expected 22", v8); end
      checks++; if (isr8 !== 8'h00) begin failures++; $display("FAIL aeoi_isr_ir2: got %h expected 00", isr8); end
      do_inta(v8, e8, v16);
      checks++; if (v8 !== 8'h20) begin failures++; $display("FAIL aeoi_rotate_second: got %h expected 20", v8); end
   endtask

   task automatic test_mask16();
      logic [7:0] v8, v16;
      logic       e8;
      init(8'h13, 8'h20, 8'h01, 8'hFF);
      wr(S_OCW1, 8'hFF);
      wr(S_OCW1, 8'hFF);
      ir16 = 16'h8000; tick(); tick();
      checks++; if (int16 !== 1'b0) begin failures++; $display("FAIL mask_ir15: got %b expected 0", int16); end
      ir16 = 16'h8080; tick(); tick();
      checks++; if (int16 !== 1'b0) begin failures++; $display("FAIL mask_ir7: got %b expected 0", int16); end
      wr(S_OCW3, 8'h08);
      wr(S_OCW1, 8'hFF);
      wr(S_OCW1, 8'h7F);
      checks++; if (imr16 !== 16'h7FFF) begin failures++; $display("FAIL mask_imr16: got %h expected 7fff", imr16); end
      tick();
      checks++; if (int16 !== 1'b1) begin failures++; $display("FAIL mask_unmask_int: got %b expected 1", int16); end
      do_inta(v8, e8, v16);
      checks++; if (v16 !== 8'h2F) begin failures++; $display("FAIL mask_vec16: got %h expected 2f", v16); end
      checks++; if (isr16 !== 16'h8000) begin failures++; $display("FAIL mask_isr16: got %h expected 8000", isr16); end
      ir16 = 16'h0000;
   endtask

   task automatic test_poll();
      init(8'h13, 8'h20, 8'h01, 8'h00);
      ir8 = 8'h20; tick(); ir8 = 8'h00; tick();
      wr(S_OCW3, 8'h0C);
      read = 1'b1; tick();
      checks++; if (en8 !== 1'b1 || data8 !== 8'h85) begin failures++; $display("FAIL poll_word: got en=%b data=%h expected en=1 data=85", en8, data8); end
      checks++; if (isr8 !== 8'h20) begin failures++; $display("FAIL poll_isr: got %h expected 20", isr8); end
      read = 1'b0; tick();
      checks++; if (en8 !== 1'b0) begin failures++; $display("FAIL poll_release: got %b expected 0", en8); end
      wr(S_OCW3, 8'h0A);
      read = 1'b1; tick();
      checks++; if (en8 !== 1'b1 || data8 !== 8'h00) begin failures++; $display("FAIL poll_irr_read: got en=%b data=%h expected en=1 data=00", en8, data8); end
      read = 1'b0; tick();
      wr(S_OCW3, 8'h0C);
      read = 1'b1; tick();
      checks++; if (data8 !== 8'h07) begin failures++; $display("FAIL poll_empty: got %h expected 07", data8); end
      read = 1'b0; tick();
      wr(S_OCW3, 8'h0B);
      read = 1'b1; tick();
      checks++; if (data8 !== 8'h20) begin failures++; $display("FAIL poll_isr_read: got %h expected 20", data8); end
      read = 1'b0; tick();
   endtask

   task automatic test_spurious();
      logic [7:0] v8, v16;
      logic       e8;
      init(8'h1B, 8'h20, 8'h01, 8'h00);
      ir8 = 8'h10; tick(); tick();
      checks++; if (int8 !== 1'b1) begin failures++; $display("FAIL spur_level_int: got %b expected 1", int8); end
      ir8 = 8'h00; tick(); tick();
      checks++; if (int8 !== 1'b0) begin failures++; $display("FAIL spur_level_drop: got %b expected 0", int8); end
      do_inta(v8, e8, v16);
      checks++; if (e8 !== 1'b1 || v8 !== 8'h27) begin failures++; $display("FAIL spur_vector: got en=%b data=%h expected en=1 data=27", e8, v8); end
      checks++; if (isr8 !== 8'h00) begin failures++; $display("FAIL spur_isr: got %h expected 00", isr8); end
   endtask

   task automatic test_icw1_abort();
      init(8'h13, 8'h20, 8'h01, 8'h01);
      ir8 = 8'h40; tick(); tick();
      checks++; if (int8 !== 1'b1) begin failures++; $display("FAIL abort_int: got %b expected 1", int8); end
      inta_n = 1'b0; tick();
      checks++; if (isr8 !== 8'h40 || imr8 !== 8'h01) begin failures++; $display("FAIL abort_pre: got isr=%h imr=%h expected isr=40 imr=01", isr8, imr8); end
      wr(S_ICW1, 8'h13);
      checks++; if (en8 !== 1'b0 || int8 !== 1'b0) begin failures++; $display("FAIL abort_outputs: got en=%b int=%b expected 0/0", en8, int8); end
      checks++; if (isr8 !== 8'h00 || imr8 !== 8'h00) begin failures++; $display("FAIL abort_regs: got isr=%h imr=%h expected 00/00", isr8, imr8); end
      inta_n = 1'b1; tick(); tick();
      checks++; if (int8 !== 1'b0) begin failures++; $display("FAIL abort_no_int: got %b expected 0", int8); end
      read = 1'b1; tick();
      checks++; if (en8 !== 1'b1 || data8 !== 8'h00) begin failures++; $display("FAIL abort_idle_irr: got en=%b data=%h expected en=1 data=00", en8, data8); end
      read = 1'b0; tick();
      ir8 = 8'h00;
   endtask

   initial begin
      stb    = '0;
      bus    = '0;
      read   = 1'b0;
      inta_n = 1'b1;
      ir8    = '0;
      ir16   = '0;
      test_reset();
      test_basic_ack();
      test_aeoi_rotate();
      test_mask16();
      test_poll();
      test_spurious();
      test_icw1_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pic_control_sequencer.md
Name:
pic_control_sequencer

Overview:
Clocked, parametrised successor to the 8259A control logic. It covers ICW/OCW command sequencing, IRR/ISR/IMR storage, rotating-priority resolution, the 8086 two-pulse acknowledge, poll mode and multi-byte register access for NUM_IRQ request lines. It sits between the bus-interface decode strobes and the CPU INT/INTA pins, in place of the asynchronous control logic.

Parameters:
NUM_IRQ, 8, number of request lines; legal values 8, 16, 32.
ID_WIDTH, $clog2(NUM_IRQ), width of a level index; derived, not overridden.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
write_initial_command_word_1  input  1  one-cycle ICW1 strobe.
write_initial_command_word_2_4  input  1  one-cycle ICW2/3/4 strobe.
write_operation_control_word_1  input  1  one-cycle OCW1 strobe.
write_operation_control_word_2  input  1  one-cycle OCW2 strobe.
write_operation_control_word_3  input  1  one-cycle OCW3 strobe.
read  input  1  level read strobe, synchronous to clock.
internal_data_bus  input  8  write data.
interrupt_acknowledge_n  input  1  INTA#, synchronous to clock.
interrupt_request  input  NUM_IRQ  IR lines, synchronous to clock.
interrupt_to_cpu  output  1  registered INT.
out_control_logic_data  output  1  drive enable for control_logic_data.
control_logic_data  output  8  vector, poll word or register byte.
interrupt_mask  output  NUM_IRQ  IMR.
in_service  output  NUM_IRQ  ISR.

Behaviour:
- Reset (async), or an ICW1 write (sync): IRR, ISR and IMR are 0. Vector base is 0. Edge-triggered mode, AEOI off, auto-rotate off. Lowest-priority pointer = NUM_IRQ-1. Byte pointers = 0. Ack FSM = IDLE. All outputs are 0.
- Command FSM states: CMD_READY, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4.
  - ICW1 → WAIT_ICW2. It latches LTIM=bit3, SNGL=bit1, IC4=bit0.
  - ICW2 stores base = data[7:ID_WIDTH], then goes to WAIT_ICW3 if SNGL=0, else WAIT_ICW4 if IC4=1, else CMD_READY.
  - ICW3 is accepted and discarded (no cascade support), then goes to WAIT_ICW4 if IC4=1, else CMD_READY.
  - ICW4: AEOI=bit1; uPM bit0 is ignored (8086 mode only); → CMD_READY.
  - OCW strobes are ignored outside CMD_READY.
- OCW1: writes IMR byte[mask_ptr]. mask_ptr then increments modulo NUM_IRQ/8 and is reset to 0 by any OCW3.
- OCW2 (data[7:5]):
  - 001: non-specific EOI; clears the highest-priority ISR bit.
  - 101: same as 001, and sets lowest pointer to the cleared level.
  - 100: sets auto-rotate.
  - 000: clears auto-rotate.
  - Other codes: no effect. EOI with ISR=0: no effect.
- IRR:
  - Edge mode: bit sets on a 0→1 change of the registered request.
  - Level mode: bit follows the line.
  - Bit clears when its level is acknowledged.
- Resolver:
  - pending = IRR & ~IMR.
  - The winner is the first pending bit scanning from (lowest+1) mod NUM_IRQ upward with wrap.
  - The winner is valid only if its priority is above every ISR bit (fully nested).
  - interrupt_to_cpu = registered winner_valid, one cycle latency. It is held 0 while the ack FSM is not IDLE.
- Ack FSM: IDLE → ACK1 → ACK2 → IDLE; also IDLE → POLL → IDLE. The INTA# falling edge is detected from a one-cycle-delayed copy.
  - IDLE, falling edge: latch winner id, set its ISR bit, clear its IRR bit, go to ACK1.
  - If no valid winner at that edge: spurious; id = NUM_IRQ-1, ISR unchanged.
  - ACK1: out_control_logic_data=0; on INTA# rising edge → ACK2.
  - ACK2: while INTA#=0, drive out_control_logic_data=1 and control_logic_data = {base, id}.
  - ACK2, on rising edge → IDLE. If AEOI, clear that ISR bit that cycle. If AEOI and auto-rotate, lowest = id.
- Poll: OCW3 with bit2=1 → POLL and freezes the winner. While read=1, drive {winner_valid, 7-ID_WIDTH zeros, id}. On the first read cycle, if valid, set ISR and clear IRR. On read falling edge → IDLE.
- Register read:
  - OCW3 bits1:0 = 10 selects IRR; 11 selects ISR; 0x keeps the selection.
  - In IDLE with read=1, drive byte[rd_ptr] of the selected register.
  - rd_ptr advances on read falling edge (modulo NUM_IRQ/8) and resets on OCW3.
- Simultaneous events:
  - ICW1 overrides everything in the same cycle.
  - An EOI coinciding with an ack ISR set applies the set first, then the clear of the previously highest bit.
  - An INTA# edge during POLL is ignored.

Decomposition:
- Package pic_pkg: command-state and ack-state enums, OCW2 code constants (EOI_NONSPEC=3'b001, EOI_ROTATE=3'b101, AEOI_ROT_SET=3'b100, AEOI_ROT_CLR=3'b000), and OCW3 read-select constants.
- Sub-module pic_priority_resolver(NUM_IRQ): combinational rotate, find-first, rotate-back, plus the ISR nesting check.

Test Plan:
- ICW1=0x13, ICW2=0x20, ICW4=0x01, OCW1=0x00; pulse IR3; two INTA# pulses → INT high 1 cycle after IR3 edge; ISR=0x08; second-pulse data=0x23; OCW2=0x20 → ISR=0x00.
- AEOI (ICW4=0x03) with OCW2=0x80; IR1 then IR2 acknowledged → ISR=0 after each second pulse; lowest pointer=1, so the next simultaneous IR0+IR2 resolves IR2 first.
- NUM_IRQ=16, two OCW1 writes 0xFF, 0x7F; assert IR15 → no INT. Assert IR7 → no INT (masked). Clear byte1 bit7 → INT, vector = {base[7:4], 4'hF}.
- OCW3=0x0C with IR5 pending, then read → data 0x85, ISR bit5 set, IRR bit5 clear; read with nothing pending → 0x07.
- INTA# with IR withdrawn before the ack (level mode) → spurious vector base|7, ISR unchanged.
- ICW1 write mid-ACK1 → FSM IDLE, ISR/IMR/IRR cleared, out_control_logic_data=0 the next cycle.
